// File: rtl/if_id_inst_buffer.sv
// Fetch-to-decode instruction buffer: a small circular FIFO of {pc, inst}.
// Ports: fetch side in_valid/in_ready/in_pc/in_inst, decode side out_valid/out_ready/out_pc/out_inst, flush, count.
module if_id_inst_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          push, pop;

  // Ready comes from registered occupancy only, so a pop never frees
  // a slot for a same-cycle push.
  assign in_ready  = (count_q != FULL);
  assign out_valid = out_valid_q;
  assign count     = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid_q && out_ready && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case (1'b1)
        push && !pop: count_d = count_q + 1'b1;
        pop && !push: count_d = count_q - 1'b1;
        default:      count_d = count_q;
      endcase
    end
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage is deliberately left uninitialised; occupancy guards reads.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= '{pc: in_pc, inst: in_inst};
    end
  end

  always_comb begin
    out_pc   = 32'h0;
    out_inst = NOP_INST;
    if (out_valid_q) begin
      out_pc   = mem_q[rd_ptr_q].pc;
      out_inst = mem_q[rd_ptr_q].inst;
    end
  end

endmodule

// File: tb/tb_if_id_inst_buffer.sv
// Directed bench for if_id_inst_buffer.
// Drives fetch/decode handshakes and checks outputs #1 after each edge.
module tb_if_id_inst_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int checks;
  int failures;

  if_id_inst_buffer #(
    .DEPTH(4),
    .NOP_INST(32'h00000013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hABCD0093;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    out_ready = 1'b0;

    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_inst", 64'(out_inst), 64'h13);
    check("rst_pc", 64'(out_pc), 64'd0);

    in_valid  = 1'b1;
    in_pc     = 32'h0;
    in_inst   = 32'h00500093;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sp_valid", 64'(out_valid), 64'd1);
    check("sp_inst", 64'(out_inst), 64'h00500093);
    check("sp_count1", 64'(count), 64'd1);
    tick();
    check("sp_count0", 64'(count), 64'd0);
    check("sp_empty_inst", 64'(out_inst), 64'h13);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i));
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h10);
    tick();
    check("full_ign_cnt", 64'(count), 64'd4);
    check("full_ign_pc", 64'(out_pc), 64'h0);
    out_ready = 1'b1;
    tick();
    check("full_pop_cnt", 64'(count), 64'd3);
    check("full_pop_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("drain_pc", 64'(out_pc), 64'(4 * i));
      check("drain_inst", 64'(out_inst), 64'(inst_of(32'(4 * i))));
      tick();
    end
    check("drain_valid", 64'(out_valid), 64'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * i));
      tick();
      check("wrap_pc", 64'(out_pc), 64'(4 * i));
      check("wrap_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("wrap_end", 64'(count), 64'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      tick();
    end
    check("fl_pre", 64'(count), 64'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h40);
    tick();
    flush    = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    drive(1'b1, 32'h80);
    tick();
    in_valid = 1'b0;
    check("fl_new_cnt", 64'(count), 64'd1);
    check("fl_new_pc", 64'(out_pc), 64'h80);
    out_ready = 1'b1;
    tick();
    check("fl_alone", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    drive(1'b1, 32'h200);
    tick();
    drive(1'b1, 32'h204);
    tick();
    check("st_pre", 64'(count), 64'd2);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k));
      tick();
      check("st_pc", 64'(out_pc), 64'h200);
      check("st_inst", 64'(out_inst), 64'(inst_of(32'h200)));
      check("st_count", 64'(count), (k < 1) ? 64'd3 : 64'd4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("st_d0", 64'(out_pc), 64'h200);
    tick();
    check("st_d1", 64'(out_pc), 64'h204);
    tick();
    check("st_d2", 64'(out_pc), 64'h300);
    tick();
    check("st_d3", 64'(out_pc), 64'h304);
    out_ready = 1'b0;

    drive(1'b1, 32'h500);
    tick();
    drive(1'b1, 32'h504);
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("mid_rst_cnt", 64'(count), 64'd0);
    check("mid_rst_inst", 64'(out_inst), 64'h13);
    check("mid_rst_vld", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
